mdu_sequencer: RTL
==================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle controller for the RV32M ops (MUL..REMU, alu_ctl codes 5'b00010..5'b01001).
//  Sits beside the ALU in EX. It accepts one M-op, stalls the pipeline while it iterates,
//  then returns a single-cycle result pulse tagged with its destination register.
//  Division is a radix-2 restoring divider run by an internal iteration counter.
// PARAMETERS
//  XLEN      32  operand/result width (only 32 is supported)
//  CNT_W     5   iteration counter width, log2(XLEN)
// PORTS
//  clk        in   1     single clock; every register updates on its rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     synchronous abort of the in-flight op (branch/jump redirect)
//  req_valid  in   1     EX stage presents an M-op
//  req_ready  out  1     sequencer can accept a request
//  op         in   5     alu_ctl code: MUL=02 MULH=03 MULHSU=04 MULHU=05 DIV=06 DIVU=07 REM=08 REMU=09
//  rs1_val    in   XLEN  operand A (dividend / multiplicand)
//  rs2_val    in   XLEN  operand B (divisor / multiplier)
//  rd_in      in   5     destination register of the request
//  stall      out  1     freeze IF/ID/EX while high
//  resp_valid out  1     one-cycle result pulse
//  resp_data  out  XLEN  result; valid only while resp_valid=1
//  resp_rd    out  5     destination register; valid only while resp_valid=1
// BEHAVIOUR
//  - Reset values: state=IDLE, cnt=0, req_ready=1, stall=0, resp_valid=0, resp_data=0, resp_rd=0.
//  - States and transitions:
//      IDLE -> CALC on accept.
//      IDLE -> DONE on accept of a fast-path op.
//      CALC -> DONE after the last iteration.
//      DONE -> IDLE unconditionally.
//  - Accept: req_valid & req_ready & op in 02..09. Other op codes are ignored: no state change, stall=0.
//  - req_ready = (state==IDLE).
//  - stall (combinational) = (state==IDLE & req_valid & op is M) | (state==CALC). Low in DONE, so
//    the pipeline advances in the same cycle it captures resp_data.
//  - Division setup: latch |A| and |B| (magnitudes for DIV/REM; raw values for DIVU/REMU), sign flags, rd.
//  - Division iterations: 32 CALC cycles, cnt 0..31. Each cycle does shift rem:quo left 1, subtract
//    divisor, restore if negative.
//  - Division sign fix in DONE: quotient negated if signs differed; remainder takes dividend's sign.
//  - Division latency: accept at cycle 0, resp_valid at cycle 33.
//  - Fast path (IDLE->DONE, resp_valid at cycle 1):
//      B==0: quotient = 0xFFFFFFFF (DIV/DIVU), remainder = A (REM/REMU).
//      DIV/REM overflow, A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//  - MUL returns low 32 bits of the product.
//  - MULH/MULHSU/MULHU return the high 32 bits of the 64-bit product: signed*signed,
//    signed*unsigned, unsigned*unsigned respectively.
//  - flush or rst in any state: next state IDLE, no resp_valid, cnt cleared, latched operands discarded.
//  - flush and req_valid in the same cycle: flush wins and the request is dropped.
//  - The same op delivered again after a flush restarts from cycle 0.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined:
//    - MUL* computed by one registered 33x33 signed multiply.
//    - IDLE->DONE, resp_valid at cycle 1.
//  MDU_FAST_MUL_EN undefined:
//    - MUL* uses a 32-iteration shift-add through CALC, sharing cnt and the 64-bit accumulator with
//      the divider.
//    - Operands are handled as magnitudes with a final sign fix; resp_valid at cycle 33.
//  Divide behaviour is identical in both builds.
// STRUCTURE
//  - mdu_pkg: alu_ctl localparams for codes 02..09, state encoding (IDLE/CALC/DONE), XLEN.
//  - One sub-module, mdu_div_step: combinational single restoring iteration
//    (rem_in, quo_in, divisor -> rem_out, quo_out). Instantiated once; the FSM, counter and sign
//    logic live in mdu_sequencer.
// TESTING
//  1. DIVU 100/7 -> resp_data=14 at cycle 33, stall high cycles 0-32. REMU 100/7 -> 2.
//  2. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF.
//  3. DIVU 5/0 -> 0xFFFFFFFF at cycle 1. REMU 5/0 -> 5. stall high only in cycle 0.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM -> 0.
//  5. A=B=0xFFFFFFFF:
//       MULH -> 0, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF, MUL -> 1.
//       Latency is 1 with MDU_FAST_MUL_EN, 33 without.
//  6. DIV started, flush at cycle 10 -> no resp_valid, req_ready=1 at cycle 11; a new DIVU 9/3
//     accepted then returns 3 at +33. Repeat with rst instead of flush; same result.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M sequencer: alu_ctl op codes, FSM state encoding, widths.
// Also carries the small op-class decode helpers used by the top level.
package mdu_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [4:0] OP_MUL    = 5'h02;
   localparam logic [4:0] OP_MULH   = 5'h03;
   localparam logic [4:0] OP_MULHSU = 5'h04;
   localparam logic [4:0] OP_MULHU  = 5'h05;
   localparam logic [4:0] OP_DIV    = 5'h06;
   localparam logic [4:0] OP_DIVU   = 5'h07;
   localparam logic [4:0] OP_REM    = 5'h08;
   localparam logic [4:0] OP_REMU   = 5'h09;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic op_is_m(input logic [4:0] op);
      return (op >= OP_MUL) && (op <= OP_REMU);
   endfunction

   function automatic logic op_is_div(input logic [4:0] op);
      return (op >= OP_DIV) && (op <= OP_REMU);
   endfunction

   function automatic logic op_is_rem(input logic [4:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift rem:quo left, trial-subtract the divisor, keep or restore.
// Purely combinational; rem_in is always below divisor, so the shifted value fits in XLEN+1 bits.
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            ge;

   always_comb begin
      shifted = {rem_in, quo_in[XLEN-1]};
      ge      = shifted >= {1'b0, divisor};
      // When ge holds the true difference is below divisor, so the modulo-2^XLEN subtract is exact.
      diff    = shifted[XLEN-1:0] - divisor;
      rem_out = ge ? diff : shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], ge};
   end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: divide 33 cycles (1 on /0 or overflow), multiply 1 cycle with
// MDU_FAST_MUL_EN else 33; holds req_ready low and stalls the pipe while busy, flush aborts.
module mdu_sequencer
   import mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_rd
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2*XLEN-1:0]       acc_q, acc_d;
   logic [XLEN-1:0]         opb_q, opb_d;
   logic [4:0]              op_q, op_d;
   logic [4:0]              rd_q, rd_d;
   logic                    neg_q, neg_d;
   logic                    rem_neg_q, rem_neg_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]         resp_data_q, resp_data_d;
   logic [4:0]              resp_rd_q, resp_rd_d;

   logic                    is_m, accept;
   logic                    req_div, req_sdiv, a_signed, b_signed;
   logic                    a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]         a_mag, b_mag, fast_div_res;
   logic [XLEN-1:0]         div_rem, div_quo, quo_fix, rem_fix, calc_res;
   logic [XLEN:0]           mul_sum;
   logic [2*XLEN-1:0]       mul_acc, prod_fix, step_acc;
`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]    fm_a, fm_b;
   logic signed [2*XLEN-1:0] fm_prod;
   logic [XLEN-1:0]         fm_res;
`endif

   mdu_div_step u_div_step (
      .rem_in  (acc_q[2*XLEN-1:XLEN]),
      .quo_in  (acc_q[XLEN-1:0]),
      .divisor (opb_q),
      .rem_out (div_rem),
      .quo_out (div_quo)
   );

   // Request decode: signedness of each operand depends on the op, magnitudes feed both iterators.
   always_comb begin
      is_m     = op_is_m(op);
      accept   = req_valid && (state_q == ST_IDLE) && is_m && !flush;
      req_div  = op_is_div(op);
      req_sdiv = (op == OP_DIV) || (op == OP_REM);
      a_signed = req_sdiv || (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
      b_signed = req_sdiv || (op == OP_MUL) || (op == OP_MULH);
      a_neg    = a_signed && rs1_val[XLEN-1];
      b_neg    = b_signed && rs2_val[XLEN-1];
      a_mag    = a_neg ? -rs1_val : rs1_val;
      b_mag    = b_neg ? -rs2_val : rs2_val;
      div_zero = req_div && (rs2_val == '0);
      div_ovf  = req_sdiv && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
      if (div_zero)
         fast_div_res = op_is_rem(op) ? rs1_val : '1;
      else
         fast_div_res = op_is_rem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

`ifdef MDU_FAST_MUL_EN
   always_comb begin
      fm_a    = {a_signed && rs1_val[XLEN-1], rs1_val};
      fm_b    = {b_signed && rs2_val[XLEN-1], rs2_val};
      fm_prod = fm_a * fm_b;
      fm_res  = (op == OP_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
   end
`endif

   // Iteration datapath: acc holds rem:quo for divide, product-high:multiplier for multiply.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
      quo_fix  = neg_q ? -div_quo : div_quo;
      rem_fix  = rem_neg_q ? -div_rem : div_rem;
      prod_fix = neg_q ? -mul_acc : mul_acc;
      if (op_is_div(op_q)) begin
         step_acc = {div_rem, div_quo};
         calc_res = op_is_rem(op_q) ? rem_fix : quo_fix;
      end else begin
         step_acc = mul_acc;
         calc_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      opb_d        = opb_q;
      op_d         = op_q;
      rd_d         = rd_q;
      neg_d        = neg_q;
      rem_neg_d    = rem_neg_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_rd_d    = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d = op;
               rd_d = rd_in;
               if (div_zero || div_ovf) begin
                  state_d      = ST_DONE;
                  resp_valid_d = 1'b1;
                  resp_data_d  = fast_div_res;
                  resp_rd_d    = rd_in;
`ifdef MDU_FAST_MUL_EN
               end else if (!req_div) begin
                  state_d      = ST_DONE;
                  resp_valid_d = 1'b1;
                  resp_data_d  = fm_res;
                  resp_rd_d    = rd_in;
`endif
               end else begin
                  state_d   = ST_CALC;
                  cnt_d     = '0;
                  acc_d     = {{XLEN{1'b0}}, a_mag};
                  opb_d     = b_mag;
                  neg_d     = a_neg ^ b_neg;
                  rem_neg_d = a_neg;
               end
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d      = ST_DONE;
               resp_valid_d = 1'b1;
               resp_data_d  = calc_res;
               resp_rd_d    = rd_q;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d      = ST_IDLE;
         cnt_d        = '0;
         acc_d        = '0;
         opb_d        = '0;
         neg_d        = 1'b0;
         rem_neg_d    = 1'b0;
         resp_valid_d = 1'b0;
         resp_data_d  = '0;
         resp_rd_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         opb_q        <= '0;
         op_q         <= '0;
         rd_q         <= '0;
         neg_q        <= 1'b0;
         rem_neg_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         opb_q        <= opb_d;
         op_q         <= op_d;
         rd_q         <= rd_d;
         neg_q        <= neg_d;
         rem_neg_q    <= rem_neg_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_rd_q    <= resp_rd_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign stall      = ((state_q == ST_IDLE) && req_valid && is_m) || (state_q == ST_CALC);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;

endmodule
